// File: rtl/decode.sv
// Decode stage of the single-cycle RV64 datapath. It holds the 32 x 64-bit integer
// register file and the main control decoder.
//
// Ports:
//   clk          rising-edge clock for register-file writes
//   reset        asynchronous active-low reset; clears the register file
//   Instr        instruction word being decoded
//   ExtRegWrite  register-file write enable (driven by writeback)
//   WriteReg     register-file write address
//   WriteData    register-file write data
//   RegWrite     instruction writes rd
//   ReadData1    value of rs1 (Instr[19:15])
//   ReadData2    value of rs2 (Instr[24:20])
//   ImmExt       sign-extended immediate
//   Rd           destination register (0 when the instruction has none)
//   Branch       conditional branch
//   MemRead      data-memory read
//   MemtoReg     writeback selects memory data
//   ALUOp        ALU operation code
//   MemWrite     data-memory write
//   ALUSrc       ALU operand B is ImmExt
//   RegDst       rd comes from the R-type field
module decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        ExtRegWrite,
  input  logic [4:0]  WriteReg,
  input  logic [63:0] WriteData,
  output logic        RegWrite,
  output logic [63:0] ReadData1,
  output logic [63:0] ReadData2,
  output logic [63:0] ImmExt,
  output logic [4:0]  Rd,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic [3:0]  ALUOp,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegDst
);

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  logic [63:0] registers [32];

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = Instr[6:0];
  assign funct3 = Instr[14:12];
  assign funct7 = Instr[31:25];
  assign rs1    = Instr[19:15];
  assign rs2    = Instr[24:20];

  // Register file: x0 is never written, so it stays zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        registers[i] <= 64'd0;
      end
    end else if (ExtRegWrite && (WriteReg != 5'd0)) begin
      registers[WriteReg] <= WriteData;
    end
  end

  // No bypass: a same-cycle write is only visible after the clock edge.
  assign ReadData1 = (rs1 == 5'd0) ? 64'd0 : registers[rs1];
  assign ReadData2 = (rs2 == 5'd0) ? 64'd0 : registers[rs2];

  always_comb begin
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    RegDst   = 1'b0;
    ALUOp    = 4'b0000;
    Rd       = 5'd0;
    ImmExt   = 64'd0;

    case (opcode)
      OpRType: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        Rd       = Instr[11:7];
        if      (funct3 == 3'b000 && funct7 == 7'b0100000) ALUOp = 4'b0110;
        else if (funct3 == 3'b111 && funct7 == 7'b0000000) ALUOp = 4'b0111;
        else if (funct3 == 3'b110 && funct7 == 7'b0000000) ALUOp = 4'b0001;
        else                                                ALUOp = 4'b0010;
      end
      OpLoad: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        MemtoReg = 1'b1;
        MemRead  = 1'b1;
        Rd       = Instr[11:7];
        ImmExt   = {{52{Instr[31]}}, Instr[31:20]};
      end
      OpStore: begin
        ALUSrc   = 1'b1;
        MemWrite = 1'b1;
        ImmExt   = {{52{Instr[31]}}, Instr[31:25], Instr[11:7]};
      end
      OpBranch: begin
        Branch = 1'b1;
        ALUOp  = 4'b0001;
        ImmExt = {{51{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_decode.sv
module tb_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic        ExtRegWrite;
  logic [4:0]  WriteReg;
  logic [63:0] WriteData;
  logic        RegWrite;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  logic [63:0] ImmExt;
  logic [4:0]  Rd;
  logic        Branch;
  logic        MemRead;
  logic        MemtoReg;
  logic [3:0]  ALUOp;
  logic        MemWrite;
  logic        ALUSrc;
  logic        RegDst;

  int total = 0;
  int bad   = 0;

  logic [63:0] model_regs [32];

  decode dut (
    .clk         (clk),
    .reset       (reset),
    .Instr       (Instr),
    .ExtRegWrite (ExtRegWrite),
    .WriteReg    (WriteReg),
    .WriteData   (WriteData),
    .RegWrite    (RegWrite),
    .ReadData1   (ReadData1),
    .ReadData2   (ReadData2),
    .ImmExt      (ImmExt),
    .Rd          (Rd),
    .Branch      (Branch),
    .MemRead     (MemRead),
    .MemtoReg    (MemtoReg),
    .ALUOp       (ALUOp),
    .MemWrite    (MemWrite),
    .ALUSrc      (ALUSrc),
    .RegDst      (RegDst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the instruction-class table.
  typedef struct packed {
    logic        rw, alusrc, m2r, mr, mw, br, rdst;
    logic [3:0]  aluop;
    logic [4:0]  rd;
    logic [63:0] imm;
  } ctl_t;

  function automatic ctl_t ref_decode(input logic [31:0] i);
    ctl_t c;
    longint imm;
    int f3, f7;
    c = '0;
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    case (i[6:0])
      7'h33: begin
        c.rw = 1; c.rdst = 1; c.rd = i[11:7];
        c.aluop = (f3 == 0 && f7 == 32) ? 4'd6 :
                  (f3 == 7 && f7 == 0)  ? 4'd7 :
                  (f3 == 6 && f7 == 0)  ? 4'd1 : 4'd2;
      end
      7'h03: begin
        c.rw = 1; c.alusrc = 1; c.m2r = 1; c.mr = 1; c.rd = i[11:7];
        imm = longint'(i[31:20]);
        if (imm >= 2048) imm -= 4096;
        c.imm = imm;
      end
      7'h23: begin
        c.alusrc = 1; c.mw = 1;
        imm = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (imm >= 2048) imm -= 4096;
        c.imm = imm;
      end
      7'h63: begin
        c.br = 1; c.aluop = 4'd1;
        imm = longint'(i[31]) * 4096 + longint'(i[7]) * 2048
            + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (imm >= 4096) imm -= 8192;
        c.imm = imm;
      end
      default: ;
    endcase
    return c;
  endfunction

  task automatic apply_check(input logic [31:0] instr, input string tag);
    ctl_t e;
    Instr = instr;
    #1;
    e = ref_decode(instr);
    check($sformatf("%s.RegWrite", tag), 64'(RegWrite), 64'(e.rw));
    check($sformatf("%s.ALUSrc", tag),   64'(ALUSrc),   64'(e.alusrc));
    check($sformatf("%s.MemtoReg", tag), 64'(MemtoReg), 64'(e.m2r));
    check($sformatf("%s.MemRead", tag),  64'(MemRead),  64'(e.mr));
    check($sformatf("%s.MemWrite", tag), 64'(MemWrite), 64'(e.mw));
    check($sformatf("%s.Branch", tag),   64'(Branch),   64'(e.br));
    check($sformatf("%s.RegDst", tag),   64'(RegDst),   64'(e.rdst));
    check($sformatf("%s.ALUOp", tag),    64'(ALUOp),    64'(e.aluop));
    check($sformatf("%s.Rd", tag),       64'(Rd),       64'(e.rd));
    check($sformatf("%s.ImmExt", tag),   ImmExt,        e.imm);
    check($sformatf("%s.ReadData1", tag), ReadData1, model_regs[instr[19:15]]);
    check($sformatf("%s.ReadData2", tag), ReadData2, model_regs[instr[24:20]]);
  endtask

  // Drive a write, clock it, and update the model.
  task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
    ExtRegWrite = 1'b1;
    WriteReg    = a;
    WriteData   = d;
    @(posedge clk);
    #1;
    ExtRegWrite = 1'b0;
    if (a != 5'd0) model_regs[a] = d;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s.x%0d", tag, i), dut.registers[i], 64'd0);
    end
  endtask

  initial begin
    reset       = 1'b0;
    Instr       = 32'd0;
    ExtRegWrite = 1'b0;
    WriteReg    = 5'd0;
    WriteData   = 64'd0;
    for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;

    // Reset held low: writes ignored.
    #2;
    ExtRegWrite = 1'b1; WriteReg = 5'd5; WriteData = 64'h1234;
    @(posedge clk); #1;
    ExtRegWrite = 1'b0;
    check_all_zero("in_reset");
    reset = 1'b1;
    #1;
    check_all_zero("after_reset");

    // Zero instruction decodes to all-zero controls.
    apply_check(32'h0000_0000, "nop0");
    check("nop0.RegWrite_const", 64'(RegWrite), 64'd0);

    write_reg(5'd20, 64'hDEAD_BEEF_DEAD_BEEF);
    check("x20_write", dut.registers[20], 64'hDEAD_BEEF_DEAD_BEEF);

    write_reg(5'd0, '1);
    check("x0_write_dropped", dut.registers[0], 64'd0);
    Instr = 32'h0000_0033; #1;
    check("x0_read", ReadData1, 64'd0);

    write_reg(5'd2, 64'd2);
    write_reg(5'd3, 64'd3);
    write_reg(5'd5, 64'd5);
    write_reg(5'd6, 64'd6);

    apply_check(32'h003100B3, "add");
    check("add.ALUOp_const", 64'(ALUOp), 64'b0010);
    check("add.rd1_const", ReadData1, 64'd2);
    check("add.rd2_const", ReadData2, 64'd3);
    apply_check(32'h40628233, "sub");
    check("sub.ALUOp_const", 64'(ALUOp), 64'b0110);
    check("sub.rd1_const", ReadData1, 64'd5);
    apply_check(32'h00947433, "and");
    check("and.ALUOp_const", 64'(ALUOp), 64'b0111);
    apply_check(32'h00C5E533, "or");
    check("or.ALUOp_const", 64'(ALUOp), 64'b0001);
    apply_check(32'h00873683, "ld");
    check("ld.Imm_const", ImmExt, 64'd8);
    check("ld.Rd_const", 64'(Rd), 64'd13);
    apply_check(32'h00F83823, "sd");
    check("sd.Imm_const", ImmExt, 64'h10);
    apply_check(32'h01280863, "beq");
    check("beq.Imm_const", ImmExt, 64'h10);
    check("beq.Branch_const", 64'(Branch), 64'd1);
    apply_check(32'hFF873683, "ld_neg");
    check("ld_neg.Imm_const", ImmExt, 64'hFFFF_FFFF_FFFF_FFF8);
    apply_check(32'h0010_0033, "rtype_other");   // funct3=000 funct7=0000000 with rs2=1
    apply_check(32'h0200_0033, "rtype_mul");     // funct7=0000001 falls back to ADD code

    // No bypass: old value visible until the edge.
    Instr = 32'h0003_8033;  // rs1 = x7
    #1;
    ExtRegWrite = 1'b1; WriteReg = 5'd7; WriteData = 64'hCAFE_F00D_0000_0007;
    #1;
    check("nobypass.before", ReadData1, model_regs[7]);
    @(posedge clk); #1;
    ExtRegWrite = 1'b0;
    model_regs[7] = 64'hCAFE_F00D_0000_0007;
    check("nobypass.after", ReadData1, model_regs[7]);

    // Randomized writes and instructions.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ins;
      logic [6:0]  ops [5];
      ops[0] = 7'h33; ops[1] = 7'h03; ops[2] = 7'h23; ops[3] = 7'h63;
      ops[4] = 7'($urandom);
      write_reg(5'($urandom), {$urandom, $urandom});
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        // Bias R-type funct7 towards the decoded values.
        ins[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
      end
      ins[6:0] = ops[$urandom_range(0, 4)];
      apply_check(ins, $sformatf("rnd%0d", n));
    end

    // Mid-run reset clears asynchronously, between clock edges.
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
    apply_check(32'h40628233, "sub_in_reset");
    #5;
    reset = 1'b1;
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
